// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared widths, FSM encoding and address helper for the boot loader
package boot_loader_pkg;

    localparam int ADDR_SIZE = 16;
    localparam int WORD_SIZE = 16;

    typedef enum logic [1:0] {
        BOOT_IDLE  = 2'd0,
        BOOT_FETCH = 2'd1,
        BOOT_WRITE = 2'd2,
        BOOT_DONE  = 2'd3
    } boot_state_e;

    // Arithmetic is done in 32 bits and truncated, so address wrap-around is silent.
    function automatic logic [ADDR_SIZE-1:0] word_addr(
        input logic [31:0] base,
        input logic [31:0] index,
        input logic [31:0] step
    );
        logic [31:0] sum;
        sum = base + index * step;
        return sum[ADDR_SIZE-1:0];
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - ROM read / RAM write bundle between the boot loader and its memories
interface boot_loader_if;
    import boot_loader_pkg::*;

    logic [WORD_SIZE-1:0] bus_data;
    logic [ADDR_SIZE-1:0] rom_addr;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [WORD_SIZE-1:0] ram_wdata;
    logic                 ram_we;
    logic                 ram_wr_ready;
    logic                 busy;
    logic                 boot_done;

    modport master (
        input  bus_data,
        input  ram_wr_ready,
        output rom_addr,
        output ram_addr,
        output ram_wdata,
        output ram_we,
        output busy,
        output boot_done
    );

    modport slave (
        output bus_data,
        output ram_wr_ready,
        input  rom_addr,
        input  ram_addr,
        input  ram_wdata,
        input  ram_we,
        input  busy,
        input  boot_done
    );

endinterface

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - post-reset sequencer copying the program image from ROM into RAM
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int PROG_WORDS = 3,
    parameter int START_ADDR = 0,
    parameter int RAM_BASE   = 0,
    parameter int ADDR_STEP  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    boot_loader_if.master bus
);

    localparam int IDX_W = (PROG_WORDS > 0) ? (($clog2(PROG_WORDS + 1) > 0) ? $clog2(PROG_WORDS + 1) : 1) : 1;
    localparam logic [31:0] LAST_IDX = (PROG_WORDS > 0) ? 32'(PROG_WORDS - 1) : 32'd0;
    localparam logic [ADDR_SIZE-1:0] RST_ROM_ADDR = ADDR_SIZE'(START_ADDR);
    localparam logic [ADDR_SIZE-1:0] RST_RAM_ADDR = ADDR_SIZE'(RAM_BASE);

    boot_state_e          r_state;
    boot_state_e          w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [ADDR_SIZE-1:0] r_rom_addr;
    logic [ADDR_SIZE-1:0] w_rom_addr_nxt;
    logic [ADDR_SIZE-1:0] r_ram_addr;
    logic [ADDR_SIZE-1:0] w_ram_addr_nxt;
    logic [WORD_SIZE-1:0] r_ram_wdata;
    logic [WORD_SIZE-1:0] w_ram_wdata_nxt;
    logic                 r_ram_we;
    logic                 w_ram_we_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_boot_done;
    logic                 w_boot_done_nxt;
    logic [31:0]          w_idx32;

    assign w_idx32 = 32'(r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= BOOT_IDLE;
            r_idx       <= '0;
            r_rom_addr  <= RST_ROM_ADDR;
            r_ram_addr  <= RST_RAM_ADDR;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_boot_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_rom_addr  <= w_rom_addr_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_busy      <= w_busy_nxt;
            r_boot_done <= w_boot_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_rom_addr_nxt  = r_rom_addr;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_ram_we_nxt    = r_ram_we;
        w_busy_nxt      = r_busy;
        w_boot_done_nxt = r_boot_done;

        case (r_state)
            BOOT_IDLE: begin
                if (PROG_WORDS == 0) begin
                    w_state_nxt     = BOOT_DONE;
                    w_busy_nxt      = 1'b0;
                    w_boot_done_nxt = 1'b1;
                end else begin
                    w_state_nxt    = BOOT_FETCH;
                    w_idx_nxt      = '0;
                    w_rom_addr_nxt = RST_ROM_ADDR;
                    w_busy_nxt     = 1'b1;
                end
            end

            // rom_addr has been stable for a full cycle, so bus_data is settled here.
            BOOT_FETCH: begin
                w_ram_wdata_nxt = bus.bus_data;
                w_ram_addr_nxt  = word_addr(RAM_BASE, w_idx32, ADDR_STEP);
                w_ram_we_nxt    = 1'b1;
                w_state_nxt     = BOOT_WRITE;
            end

            BOOT_WRITE: begin
                if (bus.ram_wr_ready) begin
                    w_ram_we_nxt = 1'b0;
                    if (w_idx32 == LAST_IDX) begin
                        w_state_nxt     = BOOT_DONE;
                        w_busy_nxt      = 1'b0;
                        w_boot_done_nxt = 1'b1;
                    end else begin
                        w_idx_nxt      = r_idx + IDX_W'(1);
                        w_rom_addr_nxt = word_addr(START_ADDR, w_idx32 + 32'd1, ADDR_STEP);
                        w_state_nxt    = BOOT_FETCH;
                    end
                end
            end

            // Terminal: addresses keep their last values until the next reset.
            BOOT_DONE: begin
                w_ram_we_nxt    = 1'b0;
                w_busy_nxt      = 1'b0;
                w_boot_done_nxt = 1'b1;
            end

            default: begin
                w_state_nxt     = BOOT_IDLE;
                w_idx_nxt       = '0;
                w_rom_addr_nxt  = RST_ROM_ADDR;
                w_ram_addr_nxt  = RST_RAM_ADDR;
                w_ram_wdata_nxt = '0;
                w_ram_we_nxt    = 1'b0;
                w_busy_nxt      = 1'b0;
                w_boot_done_nxt = 1'b0;
            end
        endcase
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.ram_we    = r_ram_we;
    assign bus.busy      = r_busy;
    assign bus.boot_done = r_boot_done;

endmodule
